// File: rtl/transmitter.sv
// Slow-control frame serializer: loads an 829-bit configuration word and shifts it out LSB first on a CK_in/2 clock.
// Optional macro TRANSMITTER_RSTN_PULSE_EN inserts a 4-cycle active-low RSTn_SC pulse before each frame.
module transmitter #(
    parameter int FRAME_LEN = 829
) (
    input  logic          CK_in,
    input  logic          rst,
    input  logic          state,
    input  logic          ON_OFF_otabg,
    input  logic          ON_OFF_dac,
    input  logic          small_dac,
    input  logic [9:0]    DAC2,
    input  logic [9:0]    DAC1,
    input  logic          enb_outADC,
    input  logic          inv_startCmptGray,
    input  logic          ramp_8bit,
    input  logic          ramp_10bit,
    input  logic [127:0]  mask_OR_ch,
    input  logic          cmd_CK_mux,
    input  logic          d1_d2,
    input  logic          inv_discriADC,
    input  logic          polar_discri,
    input  logic          Enb_tristate,
    input  logic          valid_dc_fsb2,
    input  logic          sw_fsb2_50f,
    input  logic          sw_fsb2_100f,
    input  logic          sw_fsb2_100k,
    input  logic          sw_fsb2_50k,
    input  logic          valid_dc_fs,
    input  logic          cmd_fsb_fsu,
    input  logic          sw_fsb1_50f,
    input  logic          sw_fsb1_100f,
    input  logic          sw_fsb1_100k,
    input  logic          sw_fsb1_50k,
    input  logic          sw_fsu_100k,
    input  logic          sw_fsu_50k,
    input  logic          sw_fsu_25k,
    input  logic          sw_fsu_40f,
    input  logic          sw_fsu_20f,
    input  logic          H1H2_choice,
    input  logic          EN_ADC,
    input  logic          sw_ss_1200f,
    input  logic          sw_ss_600f,
    input  logic          sw_ss_300f,
    input  logic          ON_OFF_ss,
    input  logic          swb_buf_2p,
    input  logic          swb_buf_1p,
    input  logic          swb_buf_500f,
    input  logic          swb_buf_250f,
    input  logic          cmd_fsb,
    input  logic          cmd_ss,
    input  logic          cmd_fsu,
    input  logic [575:0]  GAIN,
    input  logic [63:0]   Ctest_ch,
    output logic          D_SC,
    output logic          RSTn_SC,
    output logic          CK_SC
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RST_PULSE = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } fsm_t;

    fsm_t                 fsm_reg, fsm_next;
    logic [FRAME_LEN-1:0] shift_reg, shift_next, shift_right;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 d_sc_reg, d_sc_next;
    logic                 ck_sc_reg, ck_sc_next;
    logic                 rstn_reg, rstn_next;
    logic [FRAME_LEN-1:0] frame_word;
`ifdef TRANSMITTER_RSTN_PULSE_EN
    logic [1:0]           pulse_reg, pulse_next;
`endif

    // Global-config block: cmd_CK_mux lands at the lowest bit, cmd_fsu at the highest.
    assign frame_word = {
        Ctest_ch,
        GAIN,
        cmd_fsu, cmd_ss, cmd_fsb, swb_buf_250f, swb_buf_500f, swb_buf_1p, swb_buf_2p,
        ON_OFF_ss, sw_ss_300f, sw_ss_600f, sw_ss_1200f, EN_ADC, H1H2_choice,
        sw_fsu_20f, sw_fsu_40f, sw_fsu_25k, sw_fsu_50k, sw_fsu_100k,
        sw_fsb1_50k, sw_fsb1_100k, sw_fsb1_100f, sw_fsb1_50f, cmd_fsb_fsu, valid_dc_fs,
        sw_fsb2_50k, sw_fsb2_100k, sw_fsb2_100f, sw_fsb2_50f, valid_dc_fsb2,
        Enb_tristate, polar_discri, inv_discriADC, d1_d2, cmd_CK_mux,
        mask_OR_ch,
        ramp_10bit, ramp_8bit, inv_startCmptGray, enb_outADC,
        DAC1,
        DAC2,
        small_dac, ON_OFF_dac, ON_OFF_otabg
    };

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_LEN - 1; gi++) begin : g_shift
            assign shift_right[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_right[FRAME_LEN-1] = 1'b0;

    always_ff @(posedge CK_in) begin
        if (rst) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE: begin
                if (!state) begin
`ifdef TRANSMITTER_RSTN_PULSE_EN
                    fsm_next = RST_PULSE;
`else
                    fsm_next = SHIFT;
`endif
                end
            end
`ifdef TRANSMITTER_RSTN_PULSE_EN
            RST_PULSE: begin
                if (state) begin
                    fsm_next = IDLE;
                end else if (pulse_reg == 2'd3) begin
                    fsm_next = SHIFT;
                end
            end
`endif
            SHIFT: begin
                if (state) begin
                    fsm_next = IDLE;
                end else if (ck_sc_reg && (cnt_reg == LAST_BIT)) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (state) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered so D_SC/CK_SC/RSTn_SC are glitch-free.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        d_sc_next  = 1'b0;
        ck_sc_next = 1'b0;
        rstn_next  = 1'b1;
`ifdef TRANSMITTER_RSTN_PULSE_EN
        pulse_next = pulse_reg;
`endif
        case (fsm_reg)
            IDLE: begin
                cnt_next = '0;
`ifdef TRANSMITTER_RSTN_PULSE_EN
                pulse_next = 2'd0;
`endif
                if (state) begin
                    shift_next = frame_word;
                end else begin
`ifdef TRANSMITTER_RSTN_PULSE_EN
                    rstn_next = 1'b0;
`else
                    d_sc_next = shift_reg[0];
`endif
                end
            end
`ifdef TRANSMITTER_RSTN_PULSE_EN
            RST_PULSE: begin
                if (!state) begin
                    if (pulse_reg == 2'd3) begin
                        d_sc_next = shift_reg[0];
                    end else begin
                        rstn_next  = 1'b0;
                        pulse_next = pulse_reg + 2'd1;
                    end
                end
            end
`endif
            SHIFT: begin
                if (!state) begin
                    if (!ck_sc_reg) begin
                        ck_sc_next = 1'b1;
                        d_sc_next  = d_sc_reg;
                    end else if (cnt_reg != LAST_BIT) begin
                        // Data advances only on the falling edge so it is stable across each rise.
                        shift_next = shift_right;
                        cnt_next   = cnt_reg + 1'b1;
                        d_sc_next  = shift_reg[1];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK_in) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            d_sc_reg  <= 1'b0;
            ck_sc_reg <= 1'b0;
            rstn_reg  <= 1'b0;
`ifdef TRANSMITTER_RSTN_PULSE_EN
            pulse_reg <= 2'd0;
`endif
        end else begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            d_sc_reg  <= d_sc_next;
            ck_sc_reg <= ck_sc_next;
            rstn_reg  <= rstn_next;
`ifdef TRANSMITTER_RSTN_PULSE_EN
            pulse_reg <= pulse_next;
`endif
        end
    end

    assign D_SC    = d_sc_reg;
    assign CK_SC   = ck_sc_reg;
    assign RSTn_SC = rstn_reg;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: directed and random frames captured on CK_SC rises and compared with a bit-map model.
module tb_transmitter;

`ifdef TRANSMITTER_RSTN_PULSE_EN
    localparam int PULSE_CYCLES = 4;
`else
    localparam int PULSE_CYCLES = 0;
`endif
    localparam int NBITS = 829;

    logic         CK_in = 1'b0;
    logic         rst, state;
    logic         ON_OFF_otabg, ON_OFF_dac, small_dac;
    logic [9:0]   DAC2, DAC1;
    logic         enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit;
    logic [127:0] mask_OR_ch;
    logic [33:0]  glob;
    logic [575:0] GAIN;
    logic [63:0]  Ctest_ch;
    logic         D_SC, RSTn_SC, CK_SC;

    int vectors = 0;
    int miscompares = 0;

    always #5 CK_in = ~CK_in;

    transmitter dut (
        .CK_in(CK_in), .rst(rst), .state(state),
        .ON_OFF_otabg(ON_OFF_otabg), .ON_OFF_dac(ON_OFF_dac), .small_dac(small_dac),
        .DAC2(DAC2), .DAC1(DAC1),
        .enb_outADC(enb_outADC), .inv_startCmptGray(inv_startCmptGray),
        .ramp_8bit(ramp_8bit), .ramp_10bit(ramp_10bit),
        .mask_OR_ch(mask_OR_ch),
        .cmd_CK_mux(glob[0]), .d1_d2(glob[1]), .inv_discriADC(glob[2]), .polar_discri(glob[3]),
        .Enb_tristate(glob[4]), .valid_dc_fsb2(glob[5]), .sw_fsb2_50f(glob[6]), .sw_fsb2_100f(glob[7]),
        .sw_fsb2_100k(glob[8]), .sw_fsb2_50k(glob[9]), .valid_dc_fs(glob[10]), .cmd_fsb_fsu(glob[11]),
        .sw_fsb1_50f(glob[12]), .sw_fsb1_100f(glob[13]), .sw_fsb1_100k(glob[14]), .sw_fsb1_50k(glob[15]),
        .sw_fsu_100k(glob[16]), .sw_fsu_50k(glob[17]), .sw_fsu_25k(glob[18]), .sw_fsu_40f(glob[19]),
        .sw_fsu_20f(glob[20]), .H1H2_choice(glob[21]), .EN_ADC(glob[22]), .sw_ss_1200f(glob[23]),
        .sw_ss_600f(glob[24]), .sw_ss_300f(glob[25]), .ON_OFF_ss(glob[26]), .swb_buf_2p(glob[27]),
        .swb_buf_1p(glob[28]), .swb_buf_500f(glob[29]), .swb_buf_250f(glob[30]), .cmd_fsb(glob[31]),
        .cmd_ss(glob[32]), .cmd_fsu(glob[33]),
        .GAIN(GAIN), .Ctest_ch(Ctest_ch),
        .D_SC(D_SC), .RSTn_SC(RSTn_SC), .CK_SC(CK_SC)
    );

    task automatic check(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame placed field by field from the documented bit map.
    function automatic logic [NBITS-1:0] build_frame();
        logic [NBITS-1:0] f;
        f = '0;
        f[0] = ON_OFF_otabg;
        f[1] = ON_OFF_dac;
        f[2] = small_dac;
        for (int i = 0; i < 10; i++) begin
            f[3 + i]  = DAC2[i];
            f[13 + i] = DAC1[i];
        end
        f[23] = enb_outADC;
        f[24] = inv_startCmptGray;
        f[25] = ramp_8bit;
        f[26] = ramp_10bit;
        for (int i = 0; i < 128; i++) f[27 + i] = mask_OR_ch[i];
        for (int i = 0; i < 34; i++)  f[155 + i] = glob[i];
        for (int i = 0; i < 576; i++) f[189 + i] = GAIN[i];
        for (int i = 0; i < 64; i++)  f[765 + i] = Ctest_ch[i];
        return f;
    endfunction

    task automatic clear_inputs();
        {ON_OFF_otabg, ON_OFF_dac, small_dac} = '0;
        DAC2 = '0; DAC1 = '0;
        {enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit} = '0;
        mask_OR_ch = '0; glob = '0; GAIN = '0; Ctest_ch = '0;
    endtask

    task automatic randomize_inputs();
        {ON_OFF_otabg, ON_OFF_dac, small_dac} = 3'($urandom);
        DAC2 = 10'($urandom);
        DAC1 = 10'($urandom);
        {enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit} = 4'($urandom);
        for (int i = 0; i < 4; i++)  mask_OR_ch[i*32 +: 32] = $urandom;
        glob = {2'($urandom), $urandom};
        for (int i = 0; i < 18; i++) GAIN[i*32 +: 32] = $urandom;
        for (int i = 0; i < 2; i++)  Ctest_ch[i*32 +: 32] = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CK_in);
    endtask

    // Starts a frame and samples at every negedge; returns on DONE, on abort, or on budget expiry.
    task automatic run_frame(input int abort_at, input bit poke_dac1,
                             output logic [NBITS-1:0] cap, output int rises, output int first_lat,
                             output int rstn_low, output int shift_cycles, output bit timed_out);
        int  cyc;
        bit  prev;
        cap = '0; rises = 0; first_lat = -1; rstn_low = 0; shift_cycles = 0; timed_out = 1;
        prev = 1'b0;
        @(negedge CK_in);
        state = 1'b0;
        @(posedge CK_in);
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge CK_in);
            cyc++;
            if (!RSTn_SC) rstn_low++;
            if (CK_SC && !prev) begin
                rises++;
                cap = {D_SC, cap[NBITS-1:1]};
                if (first_lat < 0) first_lat = cyc - 1;
            end
            prev = CK_SC;
            if (poke_dac1 && cyc == 40) DAC1 = 10'h3FF;
            if (abort_at > 0 && rises == abort_at) begin
                state = 1'b1;
                timed_out = 0;
                return;
            end
            if (rises == NBITS && !CK_SC) begin
                shift_cycles = cyc - 1 - PULSE_CYCLES;
                timed_out = 0;
                return;
            end
        end
    endtask

    task automatic full_frame(input string name, input logic [NBITS-1:0] exp, input bit poke);
        logic [NBITS-1:0] cap;
        int rises, first_lat, rstn_low, shift_cycles;
        bit timed_out;
        run_frame(0, poke, cap, rises, first_lat, rstn_low, shift_cycles, timed_out);
        check({name, "_timeout"}, NBITS'(timed_out), '0);
        check({name, "_frame"}, cap, exp);
        check({name, "_rises"}, NBITS'(rises), NBITS'(NBITS));
        check({name, "_first_rise_lat"}, NBITS'(first_lat), NBITS'(1 + PULSE_CYCLES));
        check({name, "_rstn_low"}, NBITS'(rstn_low), NBITS'(PULSE_CYCLES));
        check({name, "_shift_cycles"}, NBITS'(shift_cycles), NBITS'(2 * NBITS));
        if (poke) check({name, "_dac1_field"}, NBITS'(cap[22:13]), NBITS'(exp[22:13]));
        $display("frame %s: %0d bits, first rise after %0d cycles", name, rises, first_lat);
    endtask

    initial begin
        logic [NBITS-1:0] exp, cap;
        int rises, first_lat, rstn_low, shift_cycles, ck_seen;
        bit timed_out;

        clear_inputs();
        state = 1'b1;
        rst   = 1'b1;
        repeat (2) @(posedge CK_in);
        @(negedge CK_in);
        check("reset_d_sc", NBITS'(D_SC), '0);
        check("reset_ck_sc", NBITS'(CK_SC), '0);
        check("reset_rstn_sc", NBITS'(RSTn_SC), '0);
        rst = 1'b0;
        @(negedge CK_in);
        check("release_rstn_sc", NBITS'(RSTn_SC), NBITS'(1));
        ck_seen = 0;
        repeat (8) begin
            @(negedge CK_in);
            if (CK_SC) ck_seen++;
        end
        check("idle_ck_silent", NBITS'(ck_seen), '0);
        $display("reset sequence done");

        ON_OFF_otabg = 1'b1;
        Ctest_ch[63] = 1'b1;
        idle_cycles(2);
        exp = '0;
        exp[0] = 1'b1;
        exp[828] = 1'b1;
        full_frame("directed", exp, 1'b0);
        ck_seen = 0;
        repeat (6) begin
            @(negedge CK_in);
            if (CK_SC || D_SC || !RSTn_SC) ck_seen++;
        end
        check("done_outputs_quiet", NBITS'(ck_seen), '0);

        for (int f = 0; f < 3; f++) begin
            state = 1'b1;
            randomize_inputs();
            idle_cycles(2);
            exp = build_frame();
            full_frame($sformatf("random%0d", f), exp, 1'b0);
        end

        state = 1'b1;
        randomize_inputs();
        DAC1 = 10'h155;
        idle_cycles(2);
        exp = build_frame();
        full_frame("dac1_poke", exp, 1'b1);

        state = 1'b1;
        randomize_inputs();
        idle_cycles(2);
        run_frame(100, 1'b0, cap, rises, first_lat, rstn_low, shift_cycles, timed_out);
        check("abort_timeout", NBITS'(timed_out), '0);
        check("abort_rises", NBITS'(rises), NBITS'(100));
        @(negedge CK_in);
        check("abort_ck_sc", NBITS'(CK_SC), '0);
        check("abort_d_sc", NBITS'(D_SC), '0);
        ck_seen = 0;
        repeat (10) begin
            @(negedge CK_in);
            if (CK_SC) ck_seen++;
        end
        check("abort_ck_silent", NBITS'(ck_seen), '0);
        $display("abort after %0d bits", rises);
        randomize_inputs();
        idle_cycles(2);
        exp = build_frame();
        full_frame("after_abort", exp, 1'b0);

        state = 1'b1;
        randomize_inputs();
        idle_cycles(2);
        @(negedge CK_in);
        state = 1'b0;
        idle_cycles(50);
        rst = 1'b1;
        @(negedge CK_in);
        check("midrst_ck_sc", NBITS'(CK_SC), '0);
        check("midrst_d_sc", NBITS'(D_SC), '0);
        check("midrst_rstn_sc", NBITS'(RSTn_SC), '0);
        state = 1'b1;
        rst = 1'b0;
        @(negedge CK_in);
        check("midrst_release_rstn", NBITS'(RSTn_SC), NBITS'(1));
        check("midrst_release_ck", NBITS'(CK_SC), '0);
        $display("reset applied mid-frame");
        idle_cycles(2);
        exp = build_frame();
        full_frame("after_reset", exp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
